// File: rtl/adc_sample_filter.sv
// ---------------------------------------------------------------------------
// adc_sample_filter
//
// Sits after the ADC SPI slave receiver. It brings the receiver's
// frame-complete strobe into the system clock domain, captures one 16-bit
// word on each rising edge of that strobe, and runs a power-of-two moving
// average over the captured words. The filtered value goes to the oscillator
// pitch logic together with a one-cycle valid pulse. A watchdog flags the
// ADC stream as stale when no frame arrives for STALE_CYCLES clocks.
//
// Integration note: data_in[DATA_W-1] is the first bit shifted in (MSB), so
// receiver data_out[0] is wired to data_in[15].
//
// Parameters
//   DATA_W        sample width in bits
//   LOG2_DEPTH    log2 of the averaging window (DEPTH = 2**LOG2_DEPTH, >= 1)
//   STALE_CYCLES  idle clocks before stale asserts (>= 1)
//
// Ports
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   data_in        receiver word, held stable between frames
//   data_received  receiver frame-complete strobe (asynchronous to clock)
//   flush          synchronous clear of the averaging history
//   sample_out     filtered sample (mean of the last DEPTH captures)
//   sample_valid   one-cycle pulse when sample_out updates
//   primed         high once DEPTH samples have been captured since reset/flush
//   stale          high when no capture for STALE_CYCLES cycles
// ---------------------------------------------------------------------------
module adc_sample_filter #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned LOG2_DEPTH   = 3,
  parameter int unsigned STALE_CYCLES = 65535
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_received,
  input  logic              flush,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              primed,
  output logic              stale
);

  localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W  = DATA_W + LOG2_DEPTH;
  localparam int unsigned FILL_W = LOG2_DEPTH + 1;
  localparam int unsigned CNT_W  = (STALE_CYCLES < 2) ? 1 : $clog2(STALE_CYCLES + 1);

  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  STALE_MAX  = CNT_W'(STALE_CYCLES);
  localparam logic [CNT_W-1:0]  STALE_LAST = CNT_W'(STALE_CYCLES - 1);

  // -------------------------------------------------------------------------
  // Strobe synchroniser and rising-edge detect
  // -------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic sync3;
  logic strobe_rise;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= data_received;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // A strobe held high for any length of time produces a single capture.
  assign strobe_rise = sync2 & ~sync3;

  // -------------------------------------------------------------------------
  // Stage E: capture the receiver word
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] sample_reg;
  logic              cap_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_reg <= '0;
      cap_valid  <= 1'b0;
    end else begin
      // A flush in the edge cycle discards the frame being captured.
      cap_valid <= strobe_rise & ~flush;
      if (strobe_rise) begin
        sample_reg <= data_in;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage E+1: circular history buffer and running sum
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0]     buffer [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [FILL_W-1:0]     fill_count;
  logic [SUM_W-1:0]      sum;
  logic                  acc_valid;

  // The running sum always equals the sum of the buffer entries, so it is
  // updated by adding the incoming sample and removing the one it replaces.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buffer[i] <= '0;
      end
      wr_ptr     <= '0;
      fill_count <= '0;
      sum        <= '0;
      acc_valid  <= 1'b0;
      primed     <= 1'b0;
    end else if (flush) begin
      // Flush wins over an accumulate in the same cycle; that sample is lost.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buffer[i] <= '0;
      end
      wr_ptr     <= '0;
      fill_count <= '0;
      sum        <= '0;
      acc_valid  <= 1'b0;
      primed     <= 1'b0;
    end else begin
      acc_valid <= cap_valid;
      if (cap_valid) begin
        buffer[wr_ptr] <= sample_reg;
        sum            <= sum + SUM_W'(sample_reg) - SUM_W'(buffer[wr_ptr]);
        wr_ptr         <= wr_ptr + 1'b1;
        if (fill_count != FILL_FULL) begin
          fill_count <= fill_count + 1'b1;
        end
        if (fill_count == FILL_LAST) begin
          primed <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage E+2: divide by DEPTH and publish
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= acc_valid;
      if (acc_valid) begin
        // Truncating divide: drop the low LOG2_DEPTH bits of the sum.
        sample_out <= sum[SUM_W-1:LOG2_DEPTH];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stale stream watchdog
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] stale_cnt;

  // stale is held as its own flop so it can come out of reset asserted while
  // the counter restarts from zero; it only clears on a capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stale_cnt <= '0;
      stale     <= 1'b1;
    end else if (strobe_rise) begin
      stale_cnt <= '0;
      stale     <= 1'b0;
    end else if (stale_cnt != STALE_MAX) begin
      stale_cnt <= stale_cnt + 1'b1;
      if (stale_cnt == STALE_LAST) begin
        stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_filter.sv
module tb_adc_sample_filter;

  localparam int unsigned DW    = 16;
  localparam int unsigned LD    = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned STALE = 100;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_received = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          primed;
  logic          stale;

  always #5 clock = ~clock;

  adc_sample_filter #(
    .DATA_W      (DW),
    .LOG2_DEPTH  (LD),
    .STALE_CYCLES(STALE)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .data_received(data_received),
    .flush        (flush),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .primed       (primed),
    .stale        (stale)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] value;
    logic          primed;
  } exp_t;

  typedef struct {
    bit            flush_before;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_out;
    bit            exp_primed;
  } vec_t;

  exp_t        exp_q[$];
  int unsigned model_hist[$];
  int unsigned model_total = 0;
  int          valid_count = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  bit          check_lat = 1'b0;

  // Reference: mean over the last DEPTH captures since reset/flush, with
  // missing history counting as zero.
  function automatic exp_t model_capture(input logic [DW-1:0] d);
    exp_t        e;
    int unsigned s = 0;
    model_hist.push_back(d);
    if (model_hist.size() > DEPTH) void'(model_hist.pop_front());
    model_total++;
    foreach (model_hist[i]) s += model_hist[i];
    e.value  = DW'(s / DEPTH);
    e.primed = (model_total >= DEPTH);
    return e;
  endfunction

  function automatic void model_clear();
    model_hist.delete();
    model_total = 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin : monitor
    exp_t e;
    int   lat;
    if (sample_valid === 1'b1) begin
      valid_count++;
      if (check_lat) begin
        lat = cyc - rise_cyc;
        checks++;
        if (lat < 5 || lat > 6) begin
          errors++;
          $display("FAIL latency actual=%0d expected=5..6", lat);
        end
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 expected=0 sample_out=%h", sample_out);
      end else begin
        e = exp_q.pop_front();
        check("sample_out", 32'(sample_out), 32'(e.value));
        check("primed_at_valid", 32'(primed), 32'(e.primed));
      end
    end
  end

  // Called just after a negedge; returns just after a negedge.
  task automatic send_frame(input logic [DW-1:0] d, input int hi, input int lo, input bit push);
    data_in       = d;
    data_received = 1'b1;
    rise_cyc      = cyc;
    if (push) exp_q.push_back(model_capture(d));
    repeat (hi) @(negedge clock);
    data_received = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clock);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    model_clear();
    @(negedge clock);
  endtask

  vec_t vecs[10];

  initial begin
    int vc;
    int hi;
    int lo;

    vecs[0] = '{1'b0, 16'h8000, 16'h1000, 1'b0};
    vecs[1] = '{1'b1, 16'h1234, 16'h0246, 1'b0};
    vecs[2] = '{1'b0, 16'h1234, 16'h048D, 1'b0};
    vecs[3] = '{1'b0, 16'h1234, 16'h06D3, 1'b0};
    vecs[4] = '{1'b0, 16'h1234, 16'h091A, 1'b0};
    vecs[5] = '{1'b0, 16'h1234, 16'h0B60, 1'b0};
    vecs[6] = '{1'b0, 16'h1234, 16'h0DA7, 1'b0};
    vecs[7] = '{1'b0, 16'h1234, 16'h0FED, 1'b0};
    vecs[8] = '{1'b0, 16'h1234, 16'h1234, 1'b1};
    vecs[9] = '{1'b0, 16'h0000, 16'h0FED, 1'b1};

    // Reset held with the strobe toggling.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      data_received = ~data_received;
      data_in       = DW'($urandom);
    end
    @(negedge clock);
    check("rst_sample_out", 32'(sample_out), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_primed", 32'(primed), 32'd0);
    check("rst_stale", 32'(stale), 32'd1);
    data_received = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("rst_no_valid", 32'(valid_count), 32'd0);

    // Directed table: single frame, fill, wrap.
    check_lat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].flush_before) do_flush();
      vc = valid_count;
      void'(model_capture(vecs[i].din));
      exp_q.push_back('{vecs[i].exp_out, vecs[i].exp_primed});
      send_frame(vecs[i].din, 2, 8, 1'b0);
      wait_drain(20);
      check("one_valid_per_frame", 32'(valid_count - vc), 32'd1);
      check("stale_after_frame", 32'(stale), 32'd0);
    end
    check_lat = 1'b0;

    // Strobe held high for 100 clocks: one capture only.
    vc = valid_count;
    send_frame(16'hFFFF, 100, 10, 1'b1);
    wait_drain(20);
    check("held_strobe_valids", 32'(valid_count - vc), 32'd1);

    // Flush in the edge cycle E (rise at negedge -> sync1, sync2 -> E).
    vc = valid_count;
    data_in       = 16'h1111;
    data_received = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    model_clear();
    data_received = 1'b0;
    repeat (10) @(negedge clock);
    check("flush_collision_no_valid", 32'(valid_count - vc), 32'd0);
    check("flush_collision_primed", 32'(primed), 32'd0);
    send_frame(16'h0800, 2, 8, 1'b1);
    wait_drain(20);

    // Stale timing: capture at posedge C, stale rises exactly 100 clocks later.
    repeat (110) @(negedge clock);
    check("stale_idle", 32'(stale), 32'd1);
    data_in       = 16'h2222;
    data_received = 1'b1;
    exp_q.push_back(model_capture(16'h2222));
    repeat (3) @(posedge clock);
    #1;
    check("stale_cleared_e1", 32'(stale), 32'd0);
    data_received = 1'b0;
    repeat (99) @(posedge clock);
    @(negedge clock);
    check("stale_before_limit", 32'(stale), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("stale_at_limit", 32'(stale), 32'd1);
    check("stale_frame_drained", 32'(exp_q.size()), 32'd0);
    send_frame(16'h3333, 2, 8, 1'b1);
    wait_drain(20);
    check("stale_next_frame", 32'(stale), 32'd0);

    // Async reset at E+1: frame lost, state as after reset.
    vc = valid_count;
    data_in       = 16'h4321;
    data_received = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset_n       = 1'b0;
    data_received = 1'b0;
    model_clear();
    @(negedge clock);
    check("arst_sample_out", 32'(sample_out), 32'd0);
    check("arst_sample_valid", 32'(sample_valid), 32'd0);
    check("arst_primed", 32'(primed), 32'd0);
    check("arst_stale", 32'(stale), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (12) @(negedge clock);
    check("arst_no_valid", 32'(valid_count - vc), 32'd0);
    send_frame(16'h8000, 2, 8, 1'b1);
    wait_drain(20);

    // Randomized frames against the reference model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(7) == 0) begin
        wait_drain(30);
        do_flush();
      end
      hi = int'($urandom_range(3, 1));
      lo = ((4 - hi) < 1 ? 1 : (4 - hi)) + int'($urandom_range(2));
      send_frame(DW'($urandom), hi, lo, 1'b1);
    end
    wait_drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
